e1_clk_tune_ctrl: RTL and testbench



---
 rtl/e1_clk_tune_ctrl_pkg.sv | 24 ++
 rtl/e1_clk_tune_ctrl_sat_add.sv | 24 ++
 rtl/e1_clk_tune_ctrl.sv | 157 +++++++++++++++
 tb/tb_e1_clk_tune_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e1_clk_tune_ctrl_pkg.sv
// Shared types, widths and helpers for the E1 clock-tune loop.
package e1_clk_tune_ctrl_pkg;

   localparam int TUNE_W = 24;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRIME  = 2'd1,
      ST_ACCUM  = 2'd2,
      ST_UPDATE = 2'd3
   } state_t;

   function automatic logic signed [CNT_W:0] clamp_err(input logic signed [CNT_W:0] e,
                                                        input logic signed [CNT_W:0] lim);
      if (e > lim)
         return lim;
      else if (e < -lim)
         return -lim;
      else
         return e;
   endfunction

endpackage

// File: rtl/e1_clk_tune_ctrl_sat_add.sv
// Unsigned tune word plus signed offset, saturated to the unsigned word range.
module e1_clk_tune_ctrl_sat_add
   import e1_clk_tune_ctrl_pkg::*;
(
   input  logic        [TUNE_W-1:0] i_a,
   input  logic signed [TUNE_W:0]   i_b,
   output logic        [TUNE_W-1:0] o_sum
);

   logic [TUNE_W+1:0] w_sum;

   assign w_sum = {2'b00, i_a} + {i_b[TUNE_W], i_b};

   // Top bit set means the sum went negative; next bit set means it passed the word range.
   always_comb begin
      if (w_sum[TUNE_W+1])
         o_sum = '0;
      else if (w_sum[TUNE_W])
         o_sum = '1;
      else
         o_sum = w_sum[TUNE_W-1:0];
   end

endmodule

// File: rtl/e1_clk_tune_ctrl.sv
// Disciplines the local oscillator to the E1 RX rate by averaging per-SOF tick
// deltas and steering a 24-bit tune word split across two PDM channels.
module e1_clk_tune_ctrl
   import e1_clk_tune_ctrl_pkg::*;
#(
   parameter int TARGET    = 2048,
   parameter int LOG_AVG   = 3,      // 1..7
   parameter int ERR_CLAMP = 255,
   parameter bit INVERT    = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_cap_stb,
   input  logic [CNT_W-1:0]  i_cap_val,
   input  logic              i_cfg_en,
   input  logic              i_cfg_load,
   input  logic [TUNE_W-1:0] i_cfg_init,
   input  logic [3:0]        i_cfg_shift,
   input  logic [15:0]       i_cfg_lock_tol,
   output logic [11:0]       o_tune_hi,
   output logic [11:0]       o_tune_lo,
   output logic              o_tune_stb,
   output logic              o_locked,
   output logic              o_no_sig
);

   // state  | meaning
   // IDLE   | loop disabled, word held, locked cleared
   // PRIME  | waiting for first capture to use as reference
   // ACCUM  | accumulating clamped per-SOF errors
   // UPDATE | one cycle: apply correction and evaluate lock

   localparam int ES_W = CNT_W + 1 + LOG_AVG;

   state_t                    r_state;
   logic [TUNE_W-1:0]         r_word;
   logic [CNT_W-1:0]          r_ref;
   logic signed [ES_W-1:0]    r_err_sum;
   logic [LOG_AVG-1:0]        r_cnt;
   logic [1:0]                r_lock_cnt;
   logic                      r_locked;
   logic                      r_tune_stb;
   logic                      r_no_sig;

   logic [CNT_W-1:0]          w_delta;
   logic signed [CNT_W:0]     w_err_raw;
   logic signed [CNT_W:0]     w_err;
   logic signed [ES_W-1:0]    w_err_ext;
   logic signed [ES_W-1:0]    w_base_sum;
   logic [LOG_AVG-1:0]        w_base_cnt;
   logic signed [ES_W-1:0]    w_sh;
   logic signed [TUNE_W:0]    w_corr;
   logic signed [TUNE_W:0]    w_corr_dir;
   logic [ES_W-1:0]           w_abs;
   logic                      w_in_tol;
   logic [TUNE_W-1:0]         w_word_upd;

   assign w_delta    = i_cap_val - r_ref;
   assign w_err_raw  = $signed({1'b0, w_delta}) - $signed((CNT_W+1)'(TARGET));
   assign w_err      = clamp_err(w_err_raw, (CNT_W+1)'(ERR_CLAMP));
   assign w_err_ext  = {{LOG_AVG{w_err[CNT_W]}}, w_err};
   assign w_base_sum = (r_state == ST_UPDATE) ? '0 : r_err_sum;
   assign w_base_cnt = (r_state == ST_UPDATE) ? '0 : r_cnt;

   assign w_sh       = r_err_sum >>> i_cfg_shift;
   assign w_corr     = {{(TUNE_W+1-ES_W){w_sh[ES_W-1]}}, w_sh};
   assign w_corr_dir = INVERT ? -w_corr : w_corr;
   assign w_abs      = r_err_sum[ES_W-1] ? -r_err_sum : r_err_sum;
   assign w_in_tol   = {{16{1'b0}}, w_abs} <= {{ES_W{1'b0}}, i_cfg_lock_tol};

   e1_clk_tune_ctrl_sat_add u_sat_add (
      .i_a   (r_word),
      .i_b   (w_corr_dir),
      .o_sum (w_word_upd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_word     <= '0;
         r_ref      <= '0;
         r_err_sum  <= '0;
         r_cnt      <= '0;
         r_lock_cnt <= '0;
         r_locked   <= 1'b0;
         r_tune_stb <= 1'b0;
         r_no_sig   <= 1'b0;
      end else begin
         r_tune_stb <= 1'b0;
         if (!i_cfg_en) begin
            r_state    <= ST_IDLE;
            r_err_sum  <= '0;
            r_cnt      <= '0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: r_state <= ST_PRIME;
               ST_PRIME: begin
                  if (i_cap_stb) begin
                     r_ref   <= i_cap_val;
                     r_state <= ST_ACCUM;
                  end
               end
               ST_ACCUM, ST_UPDATE: begin
                  if (r_state == ST_UPDATE) begin
                     r_word     <= w_word_upd;
                     r_tune_stb <= 1'b1;
                     r_state    <= ST_ACCUM;
                     r_err_sum  <= '0;
                     r_cnt      <= '0;
                     // lock_cnt already at 3 means this is the 4th good window in a row
                     if (w_in_tol) begin
                        if (r_lock_cnt != 2'd3)
                           r_lock_cnt <= r_lock_cnt + 2'd1;
                        r_locked <= (r_lock_cnt == 2'd3);
                     end else begin
                        r_lock_cnt <= '0;
                        r_locked   <= 1'b0;
                     end
                  end
                  if (i_cap_stb) begin
                     r_ref <= i_cap_val;
                     if (w_delta == '0) begin
                        r_no_sig  <= 1'b1;
                        r_err_sum <= '0;
                        r_cnt     <= '0;
                     end else begin
                        r_no_sig  <= 1'b0;
                        r_err_sum <= w_base_sum + w_err_ext;
                        r_cnt     <= w_base_cnt + LOG_AVG'(1);
                        if (r_state == ST_ACCUM && r_cnt == '1)
                           r_state <= ST_UPDATE;
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
         if (i_cfg_load) begin
            r_word     <= i_cfg_init;
            r_tune_stb <= 1'b1;
            r_err_sum  <= '0;
            r_cnt      <= '0;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
         end
      end
   end

   assign o_tune_hi  = r_word[23:12];
   assign o_tune_lo  = r_word[11:0];
   assign o_tune_stb = r_tune_stb;
   assign o_locked   = r_locked;
   assign o_no_sig   = r_no_sig;

endmodule

// File: tb/tb_e1_clk_tune_ctrl.sv
// Randomized bench for e1_clk_tune_ctrl: normal and inverted-loop instances
// driven in parallel and checked against a window-level arithmetic model.
module tb_e1_clk_tune_ctrl;

   localparam int TARGET = 2048;
   localparam int N_WIN  = 8;
   localparam int CLAMP  = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_cap_stb = 1'b0;
   logic [15:0] i_cap_val = '0;
   logic        i_cfg_en = 1'b0;
   logic        i_cfg_load = 1'b0;
   logic [23:0] i_cfg_init = '0;
   logic [3:0]  i_cfg_shift = '0;
   logic [15:0] i_cfg_lock_tol = '0;

   logic [11:0] hi0, lo0, hi1, lo1;
   logic        stb0, lk0, ns0, stb1, lk1, ns1;

   always #5 clk = ~clk;

   e1_clk_tune_ctrl #(.TARGET(TARGET), .LOG_AVG(3), .ERR_CLAMP(CLAMP), .INVERT(1'b0)) u_dut (
      .clk(clk), .rst(rst), .i_cap_stb(i_cap_stb), .i_cap_val(i_cap_val),
      .i_cfg_en(i_cfg_en), .i_cfg_load(i_cfg_load), .i_cfg_init(i_cfg_init),
      .i_cfg_shift(i_cfg_shift), .i_cfg_lock_tol(i_cfg_lock_tol),
      .o_tune_hi(hi0), .o_tune_lo(lo0), .o_tune_stb(stb0), .o_locked(lk0), .o_no_sig(ns0));

   e1_clk_tune_ctrl #(.TARGET(TARGET), .LOG_AVG(3), .ERR_CLAMP(CLAMP), .INVERT(1'b1)) u_dut_inv (
      .clk(clk), .rst(rst), .i_cap_stb(i_cap_stb), .i_cap_val(i_cap_val),
      .i_cfg_en(i_cfg_en), .i_cfg_load(i_cfg_load), .i_cfg_init(i_cfg_init),
      .i_cfg_shift(i_cfg_shift), .i_cfg_lock_tol(i_cfg_lock_tol),
      .o_tune_hi(hi1), .o_tune_lo(lo1), .o_tune_stb(stb1), .o_locked(lk1), .o_no_sig(ns1));

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: window-level bookkeeping only
   int          m_phase = 0;     // 0 disabled, 1 waiting for reference, 2 running
   logic [15:0] m_ref = '0;
   logic [15:0] m_val = '0;
   int          m_sum = 0;
   int          m_cnt = 0;
   int          m_inrow = 0;
   int          m_shift = 0;
   int          m_tol = 0;
   logic [23:0] m_word [2];
   bit          m_locked = 1'b0;
   bit          m_nosig = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] sat24(input int v);
      if (v < 0) return 24'h0;
      if (v > 32'h00FF_FFFF) return 24'hFF_FFFF;
      return v[23:0];
   endfunction

   task automatic check_outs(input string tag, input bit exp_stb);
      check_val({tag, "/word"},     {8'h0, hi0, lo0}, {8'h0, m_word[0]});
      check_val({tag, "/word_inv"}, {8'h0, hi1, lo1}, {8'h0, m_word[1]});
      check_val({tag, "/stb"},      {31'h0, stb0}, {31'h0, exp_stb});
      check_val({tag, "/stb_inv"},  {31'h0, stb1}, {31'h0, exp_stb});
      check_val({tag, "/locked"},   {31'h0, lk0},  {31'h0, m_locked});
      check_val({tag, "/lock_inv"}, {31'h0, lk1},  {31'h0, m_locked});
      check_val({tag, "/no_sig"},   {31'h0, ns0},  {31'h0, m_nosig});
      check_val({tag, "/nosig_inv"},{31'h0, ns1},  {31'h0, m_nosig});
   endtask

   task automatic set_cfg(input int shift, input int tol);
      i_cfg_shift = 4'(shift);
      i_cfg_lock_tol = 16'(tol);
      m_shift = shift;
      m_tol = tol;
   endtask

   task automatic enable();
      i_cfg_en = 1'b1;
      tick();
      m_phase = 1;
   endtask

   task automatic disable_loop();
      i_cfg_en = 1'b0;
      tick();
      m_phase = 0;
      m_sum = 0;
      m_cnt = 0;
      m_inrow = 0;
      m_locked = 1'b0;
      check_outs("disable", 1'b0);
   endtask

   task automatic load(input logic [23:0] init);
      i_cfg_load = 1'b1;
      i_cfg_init = init;
      tick();
      i_cfg_load = 1'b0;
      m_word[0] = init;
      m_word[1] = init;
      m_sum = 0;
      m_cnt = 0;
      m_inrow = 0;
      m_locked = 1'b0;
      check_outs("load", 1'b1);
      tick();
      check_outs("load_after", 1'b0);
   endtask

   // One capture; optionally assert cfg_load in the cycle after it (the UPDATE cycle).
   task automatic send_cap(input logic [15:0] val, input bit load_upd, input logic [23:0] init);
      bit          done;
      logic [15:0] delta;
      int          e, corr, a;
      done = 1'b0;
      i_cap_val = val;
      i_cap_stb = 1'b1;
      tick();
      i_cap_stb = 1'b0;
      if (m_phase == 1) begin
         m_ref = val;
         m_phase = 2;
      end else if (m_phase == 2) begin
         delta = val - m_ref;
         m_ref = val;
         if (delta == 16'h0) begin
            m_nosig = 1'b1;
            m_sum = 0;
            m_cnt = 0;
         end else begin
            m_nosig = 1'b0;
            e = int'(delta) - TARGET;
            if (e > CLAMP) e = CLAMP;
            if (e < -CLAMP) e = -CLAMP;
            m_sum += e;
            m_cnt++;
            if (m_cnt == N_WIN) begin
               done = 1'b1;
               corr = m_sum >>> m_shift;
               m_word[0] = sat24(int'(m_word[0]) + corr);
               m_word[1] = sat24(int'(m_word[1]) - corr);
               a = (m_sum < 0) ? -m_sum : m_sum;
               m_inrow = (a <= m_tol) ? m_inrow + 1 : 0;
               m_locked = (m_inrow >= 4);
               m_sum = 0;
               m_cnt = 0;
            end
         end
      end
      check_val("no_sig_t1", {31'h0, ns0}, {31'h0, m_nosig});
      if (load_upd) begin
         i_cfg_load = 1'b1;
         i_cfg_init = init;
         m_word[0] = init;
         m_word[1] = init;
         m_sum = 0;
         m_cnt = 0;
         m_inrow = 0;
         m_locked = 1'b0;
      end
      tick();
      i_cfg_load = 1'b0;
      check_outs(done ? "window" : "sample", done | load_upd);
   endtask

   task automatic step(input int d);
      m_val = m_val + 16'(d);
      send_cap(m_val, 1'b0, 24'h0);
   endtask

   initial begin
      int r;
      m_word[0] = '0;
      m_word[1] = '0;
      #12;
      check_outs("reset", 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // nominal rate: zero error, lock after the 4th window
      set_cfg(0, 8);
      enable();
      load(24'h800000);
      m_val = 16'($urandom);
      send_cap(m_val, 1'b0, 24'h0);
      for (int i = 0; i < 4 * N_WIN; i++) step(2048);

      // +2 ticks per SOF: +16 per window, never locks with tol 8
      for (int i = 0; i < 3 * N_WIN; i++) step(2050);

      // counter wrap is transparent, then one large step clamps to +255
      disable_loop();
      enable();
      m_val = 16'hF700;
      send_cap(m_val, 1'b0, 24'h0);
      for (int i = 0; i < N_WIN; i++) step(2048);
      step(5000);
      for (int i = 0; i < N_WIN - 1; i++) step(2048);

      // repeated capture value flags no_sig and restarts the window
      step(2048);
      step(2048);
      step(0);
      step(2048);
      for (int i = 0; i < N_WIN - 1; i++) step(2048);

      // saturation at both ends of the word
      load(24'hFFFFF0);
      for (int i = 0; i < N_WIN; i++) step(2056);
      load(24'h000010);
      for (int i = 0; i < N_WIN; i++) step(2056);

      // load in the UPDATE cycle wins over the correction
      for (int i = 0; i < N_WIN - 1; i++) step(2060);
      m_val = m_val + 16'd2060;
      send_cap(m_val, 1'b1, 24'h123456);

      // dropping enable mid-window discards the partial sum
      for (int i = 0; i < 4; i++) step(2300);
      disable_loop();
      enable();
      send_cap(m_val, 1'b0, 24'h0);
      for (int i = 0; i < N_WIN; i++) step(2049);

      // randomized traffic
      for (int it = 0; it < 300; it++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            case ($urandom_range(0, 2))
               0: load(24'h000020);
               1: load(24'hFFFFE0);
               default: load(24'($urandom));
            endcase
         end else if (r < 8) begin
            set_cfg($urandom_range(0, 7), $urandom_range(0, 300));
         end else if (r < 10) begin
            disable_loop();
            enable();
         end else if (r < 17) begin
            step(0);
         end else if (r < 23) begin
            step(int'($urandom_range(0, 65535)));
         end else begin
            step(2048 + int'($urandom_range(0, 160)) - 80);
         end
      end

      // reset mid-window: outputs clear at once, loop stays idle until re-enabled
      set_cfg(0, 8);
      for (int i = 0; i < 3; i++) step(2100);
      #3;
      rst = 1'b1;
      i_cfg_en = 1'b0;
      #1;
      m_word[0] = '0;
      m_word[1] = '0;
      m_locked = 1'b0;
      m_nosig = 1'b0;
      m_phase = 0;
      m_sum = 0;
      m_cnt = 0;
      m_inrow = 0;
      check_outs("rst_mid", 1'b0);
      tick();
      @(negedge clk);
      rst = 1'b0;
      tick();
      for (int i = 0; i < N_WIN + 2; i++) step(2070);
      enable();
      send_cap(m_val, 1'b0, 24'h0);
      for (int i = 0; i < N_WIN; i++) step(2051);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
